// File: rtl/axi_cmd_responder.sv
// ---------------------------------------------------------------------------
// axi_cmd_responder
//
// Command-register responder for the regex coprocessor. Turns the host
// command/address/data/start-pointer registers into 32-bit BRAM writes and
// 16-bit BRAM reads, launches the matching core, supervises it with a
// timeout, and reports the run outcome through status_register.
//
// Ports:
//   clk, reset                 : system clock, synchronous active-high reset
//   data_in_register           : write data ([15:0] -> addr, [31:16] -> addr+1)
//   address_register           : half-word BRAM address (low bits used)
//   start_cc_pointer_register  : string start address handed to the core
//   cmd_register               : NOP=0, WRITE=1, READ=2, START=3, else NOP
//   status_register            : IDLE=0, RUNNING=1, ACCEPTED=2, REJECTED=3, ERROR=4
//   data_o_register            : {16'b0, last read half-word}
//   mem_addr/mem_wdata/mem_we  : registered BRAM port (host side)
//   mem_rdata                  : BRAM read data, one cycle after mem_addr
//   host_owns_mem              : 1 = responder drives BRAM, 0 = core drives it
//   core_start                 : one-cycle launch pulse
//   core_cc_pointer            : start pointer latched at launch
//   core_done, core_accept     : core completion pulse and verdict
//   core_abort                 : one-cycle pulse when the run times out
// ---------------------------------------------------------------------------
module axi_cmd_responder #(
    parameter int REG_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_WIDTH-1:0]      data_in_register,
    input  logic [REG_WIDTH-1:0]      address_register,
    input  logic [REG_WIDTH-1:0]      start_cc_pointer_register,
    input  logic [REG_WIDTH-1:0]      cmd_register,
    output logic [REG_WIDTH-1:0]      status_register,
    output logic [REG_WIDTH-1:0]      data_o_register,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]               mem_wdata,
    output logic                      mem_we,
    input  logic [15:0]               mem_rdata,
    output logic                      host_owns_mem,
    output logic                      core_start,
    output logic [REG_WIDTH-1:0]      core_cc_pointer,
    input  logic                      core_done,
    input  logic                      core_accept,
    output logic                      core_abort
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_ACCEPTED = 3'd2,
        ST_REJECTED = 3'd3,
        ST_ERROR    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_READ  = 2'd2,
        CMD_START = 2'd3
    } cmd_t;

    state_t                    state_q, state_d;
    cmd_t                      prev_cmd_q, prev_cmd_d;
    cmd_t                      cmd_dec;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]               mem_wdata_q, mem_wdata_d;
    logic                      mem_we_q, mem_we_d;
    logic                      rd_p1_q, rd_p1_d;   // read address presented to BRAM
    logic                      rd_p2_q, rd_p2_d;   // read data on mem_rdata this cycle
    logic [15:0]               dout_q, dout_d;
    logic                      core_start_q, core_start_d;
    logic                      core_abort_q, core_abort_d;
    logic [REG_WIDTH-1:0]      ptr_q, ptr_d;

    // Upper address bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];

    // Unknown command codes collapse to NOP.
    always_comb begin
        cmd_dec = CMD_NOP;
        if (cmd_register == REG_WIDTH'(1)) cmd_dec = CMD_WRITE;
        else if (cmd_register == REG_WIDTH'(2)) cmd_dec = CMD_READ;
        else if (cmd_register == REG_WIDTH'(3)) cmd_dec = CMD_START;
    end

    always_comb begin
        state_d      = state_q;
        prev_cmd_d   = cmd_dec;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        rd_p1_d      = 1'b0;
        rd_p2_d      = rd_p1_q;
        dout_d       = dout_q;
        core_start_d = 1'b0;
        core_abort_d = 1'b0;
        ptr_d        = ptr_q;

        // Reads already in flight complete regardless of the current state;
        // the BRAM sampled our address before any hand-over to the core.
        if (rd_p2_q) begin
            dout_d = mem_rdata;
        end

        if (state_q != ST_RUNNING) begin
            unique case (cmd_dec)
                CMD_WRITE: begin
                    // 32-bit writes must be half-word-pair aligned.
                    if (address_register[0]) begin
                        state_d = ST_ERROR;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = address_register[MEM_ADDR_WIDTH-1:0];
                        mem_wdata_d = data_in_register[31:0];
                    end
                end
                CMD_READ: begin
                    mem_addr_d = address_register[MEM_ADDR_WIDTH-1:0];
                    rd_p1_d    = 1'b1;
                end
                CMD_START: begin
                    // Edge-triggered so a held START launches only once.
                    if (prev_cmd_q != CMD_START) begin
                        ptr_d        = start_cc_pointer_register;
                        core_start_d = 1'b1;
                        state_d      = ST_RUNNING;
                        cnt_d        = '0;
                    end
                end
                default: ;
            endcase
        end else begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
            // A done arriving on the timeout cycle takes priority.
            if (core_done) begin
                state_d = core_accept ? ST_ACCEPTED : ST_REJECTED;
            end else if (cnt_q == CNT_LAST) begin
                core_abort_d = 1'b1;
                state_d      = ST_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prev_cmd_q   <= CMD_NOP;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            rd_p1_q      <= 1'b0;
            rd_p2_q      <= 1'b0;
            dout_q       <= '0;
            core_start_q <= 1'b0;
            core_abort_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_cmd_q   <= prev_cmd_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            rd_p1_q      <= rd_p1_d;
            rd_p2_q      <= rd_p2_d;
            dout_q       <= dout_d;
            core_start_q <= core_start_d;
            core_abort_q <= core_abort_d;
            ptr_q        <= ptr_d;
        end
    end

    assign status_register = {{(REG_WIDTH-3){1'b0}}, state_q};
    assign data_o_register = {{(REG_WIDTH-16){1'b0}}, dout_q};
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_we          = mem_we_q;
    assign host_owns_mem   = (state_q != ST_RUNNING);
    assign core_start      = core_start_q;
    assign core_abort      = core_abort_q;
    assign core_cc_pointer = ptr_q;

endmodule

// File: tb/tb_axi_cmd_responder.sv
module tb_axi_cmd_responder;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in_register, address_register, start_cc_pointer_register, cmd_register;
    logic [31:0] status_register, data_o_register, core_cc_pointer;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, host_owns_mem, core_start, core_abort, core_done, core_accept;
    logic [15:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_cmd_responder #(
        .REG_WIDTH(32), .MEM_ADDR_WIDTH(12), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .data_in_register(data_in_register),
        .address_register(address_register),
        .start_cc_pointer_register(start_cc_pointer_register),
        .cmd_register(cmd_register),
        .status_register(status_register),
        .data_o_register(data_o_register),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .host_owns_mem(host_owns_mem),
        .core_start(core_start),
        .core_cc_pointer(core_cc_pointer),
        .core_done(core_done), .core_accept(core_accept),
        .core_abort(core_abort)
    );

    // Behavioural BRAM: 32-bit write splits into two half-words, 1-cycle read.
    logic [15:0] bram [0:4095];
    always @(posedge clk) begin
        if (mem_we) begin
            bram[mem_addr]         <= mem_wdata[15:0];
            bram[mem_addr + 12'd1] <= mem_wdata[31:16];
        end
        mem_rdata <= bram[mem_addr];
    end

    typedef struct {
        logic [31:0] cmd, addr, data, ptr;
        logic        done, acc;
        logic [31:0] st;
        logic        we, start, abort, own;
        logic        chk_addr;
        logic [11:0] ea;
        logic [31:0] ewd;
        logic        chk_dout;
        logic [31:0] edo;
        logic [31:0] eptr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] cmd, addr, data, ptr, input logic done, acc,
                       input logic [31:0] st, input logic we, start, abort, own,
                       input logic chk_addr, input logic [11:0] ea, input logic [31:0] ewd,
                       input logic chk_dout, input logic [31:0] edo, input logic [31:0] eptr);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.data = data; v.ptr = ptr; v.done = done; v.acc = acc;
        v.st = st; v.we = we; v.start = start; v.abort = abort; v.own = own;
        v.chk_addr = chk_addr; v.ea = ea; v.ewd = ewd; v.chk_dout = chk_dout; v.edo = edo;
        v.eptr = eptr;
        vecs.push_back(v);
    endtask

    // Simple NOP vector with only control outputs checked.
    task automatic add_nop(input logic done, acc, input logic [31:0] st,
                           input logic abort, own, input logic [31:0] eptr);
        add(0, 0, 0, 0, done, acc, st, 0, 0, abort, own, 0, 0, 0, 0, 0, eptr);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s vec %0d actual %h required %h", nm, idx, act, exp_v);
        end
    endtask

    task automatic drive(input logic [31:0] cmd, addr, data, ptr, input logic done, acc);
        cmd_register = cmd; address_register = addr; data_in_register = data;
        start_cc_pointer_register = ptr; core_done = done; core_accept = acc;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_status", -1, status_register, 0);
        chk("rst_dout",   -1, data_o_register, 0);
        chk("rst_addr",   -1, 32'(mem_addr), 0);
        chk("rst_wdata",  -1, mem_wdata, 0);
        chk("rst_we",     -1, 32'(mem_we), 0);
        chk("rst_own",    -1, 32'(host_owns_mem), 1);
        chk("rst_start",  -1, 32'(core_start), 0);
        chk("rst_abort",  -1, 32'(core_abort), 0);
        chk("rst_ptr",    -1, core_cc_pointer, 0);
        reset = 1'b0;

        // WRITE held 3 cycles
        for (int i = 0; i < 3; i++)
            add(1, 4, 32'h0302_0001, 0, 0, 0, 0, 1, 0, 0, 1, 1, 12'd4, 32'h0302_0001, 0, 0, 0);
        add_nop(0, 0, 0, 0, 1, 0);
        // READ 4 then 5: data 2 cycles after each address
        add(2, 4, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12'd4, 0, 0, 0, 0);
        add(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12'd5, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0001, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0302, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0000_0302, 0);
        // START held 5 cycles: a single launch
        add(3, 0, 0, 32'h10, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10);
        for (int i = 0; i < 4; i++)
            add(3, 0, 0, 32'h10, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10);
        // done/accept while START still held; then stale done, no relaunch
        add(3, 0, 0, 32'h10, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h10);
        add(3, 0, 0, 32'h10, 1, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h10);
        add_nop(0, 0, 2, 0, 1, 32'h10);
        // START, WRITE while running is ignored, reject
        add(3, 0, 0, 32'h20, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h20);
        add(1, 8, 32'hDEAD_BEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h20);
        add_nop(1, 0, 3, 0, 1, 32'h20);
        // Timeout: ERROR exactly T cycles after the core_start cycle
        add(3, 0, 0, 32'h30, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h30);
        for (int i = 0; i < T - 1; i++) add_nop(0, 0, 1, 0, 0, 32'h30);
        add_nop(0, 0, 4, 1, 1, 32'h30);
        add_nop(0, 0, 4, 0, 1, 32'h30);
        // done on the timeout cycle wins, no abort
        add(3, 0, 0, 32'h40, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        for (int i = 0; i < T - 1; i++) add_nop(0, 0, 1, 0, 0, 32'h40);
        add_nop(1, 1, 2, 0, 1, 32'h40);
        add_nop(0, 0, 2, 0, 1, 32'h40);
        // odd-address write: dropped, ERROR
        add(1, 5, 32'h1111_2222, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h40);
        add_nop(0, 0, 4, 0, 1, 32'h40);
        add(3, 0, 0, 32'h50, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'h50);
        add_nop(0, 0, 1, 0, 0, 32'h50);

        foreach (vecs[i]) begin
            drive(vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].ptr, vecs[i].done, vecs[i].acc);
            @(posedge clk);
            #1;
            $display("vec %0d cmd %0d addr %0h status %0d we %0b start %0b abort %0b own %0b dout %h",
                     i, vecs[i].cmd, vecs[i].addr, status_register, mem_we, core_start,
                     core_abort, host_owns_mem, data_o_register);
            chk("status", i, status_register, vecs[i].st);
            chk("mem_we", i, 32'(mem_we), 32'(vecs[i].we));
            chk("core_start", i, 32'(core_start), 32'(vecs[i].start));
            chk("core_abort", i, 32'(core_abort), 32'(vecs[i].abort));
            chk("host_owns_mem", i, 32'(host_owns_mem), 32'(vecs[i].own));
            chk("core_cc_pointer", i, core_cc_pointer, vecs[i].eptr);
            if (vecs[i].chk_addr) chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].ea));
            if (vecs[i].we) chk("mem_wdata", i, mem_wdata, vecs[i].ewd);
            if (vecs[i].chk_dout) chk("data_o", i, data_o_register, vecs[i].edo);
        end

        // Reset mid-run: back to IDLE, host owns memory, no abort afterwards.
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        $display("reset mid-run status %0d own %0b abort %0b", status_register, host_owns_mem, core_abort);
        chk("midrun_status", -2, status_register, 0);
        chk("midrun_own", -2, 32'(host_owns_mem), 1);
        chk("midrun_abort", -2, 32'(core_abort), 0);
        chk("midrun_ptr", -2, core_cc_pointer, 0);
        reset = 1'b0;
        begin
            logic saw_abort;
            saw_abort = 1'b0;
            for (int c = 0; c < 2 * T; c++) begin
                @(posedge clk);
                #1;
                if (core_abort || status_register != 0) saw_abort = 1'b1;
            end
            $display("post-reset idle window status %0d", status_register);
            chk("post_reset_quiet", -3, 32'(saw_abort), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
